// File: rtl/riscv_trace_class_pkg.sv
// riscv_trace_class_pkg: class codes, opcode/mask constants and the pure
// instruction classifier shared by the trace classifier.
// Optional feature: RISCV_TRACE_PULP_EXT_EN enables the PULP class (8).
package riscv_trace_class_pkg;

    typedef enum logic [3:0] {
        CLS_UPPER   = 4'd0,
        CLS_JUMP    = 4'd1,
        CLS_BRANCH  = 4'd2,
        CLS_ALU     = 4'd3,
        CLS_MULDIV  = 4'd4,
        CLS_FENCE   = 4'd5,
        CLS_CSR     = 4'd6,
        CLS_SYSTEM  = 4'd7,
        CLS_PULP    = 4'd8,
        CLS_UNKNOWN = 4'd15
    } trace_class_e;

    // Size of the class code space (codes 9..14 are reserved).
    localparam int NCLASS = 16;
    // FIFO record: {pc, instr, class}
    localparam int REC_W  = 68;

    // Base opcodes
    localparam logic [6:0] OPCODE_LUI     = 7'h37;
    localparam logic [6:0] OPCODE_AUIPC   = 7'h17;
    localparam logic [6:0] OPCODE_JAL     = 7'h6f;
    localparam logic [6:0] OPCODE_JALR    = 7'h67;
    localparam logic [6:0] OPCODE_BRANCH  = 7'h63;
    localparam logic [6:0] OPCODE_OPIMM   = 7'h13;
    localparam logic [6:0] OPCODE_OP      = 7'h33;
    localparam logic [6:0] OPCODE_FENCE   = 7'h0f;
    localparam logic [6:0] OPCODE_SYSTEM  = 7'h73;
    localparam logic [6:0] OPCODE_PULP_OP = 7'h5b;

    // SYSTEM instructions matched on the full word
    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INSTR_ERET   = 32'h3020_0073;
    localparam logic [31:0] INSTR_WFI    = 32'h1050_0073;

    // Base integer ALU: OPIMM with legal shift funct7, OP with funct7 0 or SUB/SRA.
    function automatic logic is_alu(input logic [31:0] instr);
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       hit;
        opc = instr[6:0];
        f3  = instr[14:12];
        f7  = instr[31:25];
        hit = 1'b0;
        if (opc == OPCODE_OPIMM) begin
            if (f3 == 3'b001)      hit = (f7 == 7'b0000000);
            else if (f3 == 3'b101) hit = (f7 == 7'b0000000) || (f7 == 7'b0100000);
            else                   hit = 1'b1;
        end else if (opc == OPCODE_OP) begin
            if (f7 == 7'b0000000)      hit = 1'b1;
            else if (f7 == 7'b0100000) hit = (f3 == 3'b000) || (f3 == 3'b101);
        end
        return hit;
    endfunction

`ifdef RISCV_TRACE_PULP_EXT_EN
    // PULP extensions: everything on OPCODE_PULP_OP (bit manipulation,
    // PADD*/PSUB*, PMULRN) plus the OP-space groups AVG/SLET/MIN/MAX (0000010),
    // ABS/EXT (0000100), CLIP (0001010) and MAC/MSU (0100001, f3 000/001).
    function automatic logic is_pulp(input logic [31:0] instr);
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        opc = instr[6:0];
        f3  = instr[14:12];
        f7  = instr[31:25];
        return (opc == OPCODE_PULP_OP) ||
               ((opc == OPCODE_OP) &&
                ((f7 == 7'b0000010) || (f7 == 7'b0000100) || (f7 == 7'b0001010) ||
                 ((f7 == 7'b0100001) && (f3[2:1] == 2'b00))));
    endfunction
`endif

    // First match wins; PULP is tested ahead of ALU/MULDIV when enabled.
    function automatic trace_class_e classify(input logic [31:0] instr);
        logic [6:0]   opc;
        logic [2:0]   f3;
        logic [6:0]   f7;
        trace_class_e cls;
        opc = instr[6:0];
        f3  = instr[14:12];
        f7  = instr[31:25];
        cls = CLS_UNKNOWN;
        if ((opc == OPCODE_LUI) || (opc == OPCODE_AUIPC)) begin
            cls = CLS_UPPER;
        end else if ((opc == OPCODE_JAL) || ((opc == OPCODE_JALR) && (f3 == 3'b000))) begin
            cls = CLS_JUMP;
        end else if ((opc == OPCODE_BRANCH) && (f3 != 3'b010) && (f3 != 3'b011)) begin
            cls = CLS_BRANCH;
`ifdef RISCV_TRACE_PULP_EXT_EN
        end else if (is_pulp(instr)) begin
            cls = CLS_PULP;
`endif
        end else if (is_alu(instr)) begin
            cls = CLS_ALU;
        end else if ((opc == OPCODE_OP) && (f7 == 7'b0000001)) begin
            cls = CLS_MULDIV;
        end else if ((opc == OPCODE_FENCE) && ((f3 == 3'b000) || (f3 == 3'b001))) begin
            cls = CLS_FENCE;
        end else if ((opc == OPCODE_SYSTEM) && (f3 != 3'b000) && (f3 != 3'b100)) begin
            cls = CLS_CSR;
        end else if ((instr == INSTR_ECALL) || (instr == INSTR_EBREAK) ||
                     (instr == INSTR_ERET)  || (instr == INSTR_WFI)) begin
            cls = CLS_SYSTEM;
        end
        return cls;
    endfunction

    // Which class codes carry a physical counter.
    function automatic logic class_has_counter(input int code);
`ifdef RISCV_TRACE_PULP_EXT_EN
        return (code <= 8) || (code == 15);
`else
        return (code <= 7) || (code == 15);
`endif
    endfunction

endpackage

// File: rtl/riscv_trace_fifo.sv
// riscv_trace_fifo: DEPTH-entry record FIFO with log2(DEPTH)+1 bit pointers.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
// The head output reads zero while empty; there is no push-to-head bypass.
module riscv_trace_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 68
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] rdata_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q;
    logic [AW:0]  rd_ptr_q;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_push;
    logic         do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    // Pointer update; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // Storage write; contents are don't-care until covered by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/riscv_trace_classifier.sv
// riscv_trace_classifier: registers retired instructions (S1), classifies them
// (S2), buffers {pc, instr, class} records and keeps saturating class counters.
// Optional feature: RISCV_TRACE_PULP_EXT_EN adds the PULP class and counter[8].
//
// Record handshake: rec_valid_o says the FIFO head is valid; a record is
// consumed on a rising edge where rec_valid_o && rec_ready_i; rec_* stay
// stable while valid is held without ready; valid never depends on ready.
module riscv_trace_classifier #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             retire_valid_i,
    input  logic [31:0]      retire_pc_i,
    input  logic [31:0]      retire_instr_i,
    output logic             rec_valid_o,
    input  logic             rec_ready_i,
    output logic [31:0]      rec_pc_o,
    output logic [31:0]      rec_instr_o,
    output logic [3:0]       rec_class_o,
    input  logic [3:0]       cnt_sel_i,
    output logic [CNT_W-1:0] cnt_value_o,
    input  logic             cnt_clear_i,
    output logic             dropped_o
);
    import riscv_trace_class_pkg::*;

    logic              s1_valid_q;
    logic [31:0]       s1_pc_q;
    logic [31:0]       s1_instr_q;
    trace_class_e      s2_class;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              drop;
    logic [REC_W-1:0]  head;
    logic [CNT_W-1:0]  cnt_arr [NCLASS];
    logic              dropped_q;

    assign s2_class    = classify(s1_instr_q);
    assign rec_valid_o = !fifo_empty;
    assign pop         = rec_valid_o && rec_ready_i;
    assign drop        = s1_valid_q && fifo_full && !pop;

    // S1: capture the retirement port every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_pc_q    <= '0;
            s1_instr_q <= '0;
        end else begin
            s1_valid_q <= retire_valid_i;
            s1_pc_q    <= retire_pc_i;
            s1_instr_q <= retire_instr_i;
        end
    end

    riscv_trace_fifo #(
        .DEPTH (DEPTH),
        .W     (REC_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (s1_valid_q),
        .wdata_i ({s1_pc_q, s1_instr_q, 4'(s2_class)}),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .rdata_o (head)
    );

    assign rec_pc_o    = head[67:36];
    assign rec_instr_o = head[35:4];
    assign rec_class_o = head[3:0];

    for (genvar g = 0; g < NCLASS; g++) begin : g_cnt
        if (class_has_counter(g)) begin : g_on
            logic [CNT_W-1:0] cnt_q;
            // Per-class saturating counter; clear beats a same-cycle increment.
            always_ff @(posedge clk) begin
                if (rst || cnt_clear_i) begin
                    cnt_q <= '0;
                end else if (s1_valid_q && (4'(s2_class) == 4'(g)) && (cnt_q != '1)) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
            assign cnt_arr[g] = cnt_q;
        end else begin : g_off
            assign cnt_arr[g] = '0;
        end
    end

    assign cnt_value_o = cnt_arr[cnt_sel_i];

    // Sticky drop flag; a drop in the clear cycle keeps it set.
    always_ff @(posedge clk) begin
        if (rst) begin
            dropped_q <= 1'b0;
        end else if (drop) begin
            dropped_q <= 1'b1;
        end else if (cnt_clear_i) begin
            dropped_q <= 1'b0;
        end
    end

    assign dropped_o = dropped_q;

endmodule

// File: tb/tb_riscv_trace_classifier.sv
// tb_riscv_trace_classifier: directed stimulus with hand-computed classes,
// a queue-based record/counter model and a per-cycle compare process.
module tb_riscv_trace_classifier;
    localparam int DEPTH = 8;
    localparam int CNT_W = 4;
`ifdef RISCV_TRACE_PULP_EXT_EN
    localparam logic [3:0] PAVG_CLS = 4'd8;
`else
    localparam logic [3:0] PAVG_CLS = 4'd15;
`endif
    localparam logic [31:0] ADDI = 32'h0010_0093;

    logic             clk;
    logic             rst;
    logic             retire_valid_i;
    logic [31:0]      retire_pc_i;
    logic [31:0]      retire_instr_i;
    logic             rec_valid_o;
    logic             rec_ready_i;
    logic [31:0]      rec_pc_o;
    logic [31:0]      rec_instr_o;
    logic [3:0]       rec_class_o;
    logic [3:0]       cnt_sel_i;
    logic [CNT_W-1:0] cnt_value_o;
    logic             cnt_clear_i;
    logic             dropped_o;

    riscv_trace_classifier #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .retire_valid_i (retire_valid_i),
        .retire_pc_i    (retire_pc_i),
        .retire_instr_i (retire_instr_i),
        .rec_valid_o    (rec_valid_o),
        .rec_ready_i    (rec_ready_i),
        .rec_pc_o       (rec_pc_o),
        .rec_instr_o    (rec_instr_o),
        .rec_class_o    (rec_class_o),
        .cnt_sel_i      (cnt_sel_i),
        .cnt_value_o    (cnt_value_o),
        .cnt_clear_i    (cnt_clear_i),
        .dropped_o      (dropped_o)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int               checks   = 0;
    int               failures = 0;
    bit               cmp_en   = 1'b0;
    logic [67:0]      exp_q[$];
    logic [CNT_W-1:0] exp_cnt [16];
    logic             exp_dropped;
    logic             m_s1_v;
    logic [67:0]      m_s1_rec;
    logic [3:0]       drv_class;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: records pass S1 one cycle, then enter a DEPTH-deep queue.
    always @(posedge clk) begin
        bit pop_now;
        bit drop_now;
        if (rst) begin
            exp_q.delete();
            for (int i = 0; i < 16; i++) exp_cnt[i] = '0;
            exp_dropped = 1'b0;
            m_s1_v      = 1'b0;
        end else begin
            pop_now  = (exp_q.size() != 0) && rec_ready_i;
            drop_now = m_s1_v && (exp_q.size() >= DEPTH) && !pop_now;
            if (pop_now) void'(exp_q.pop_front());
            if (m_s1_v && !drop_now) exp_q.push_back(m_s1_rec);
            if (cnt_clear_i) begin
                for (int i = 0; i < 16; i++) exp_cnt[i] = '0;
                exp_dropped = drop_now;
            end else begin
                if (m_s1_v && exp_cnt[m_s1_rec[3:0]] != {CNT_W{1'b1}})
                    exp_cnt[m_s1_rec[3:0]] = exp_cnt[m_s1_rec[3:0]] + 1'b1;
                if (drop_now) exp_dropped = 1'b1;
            end
            m_s1_v   = retire_valid_i;
            m_s1_rec = {retire_pc_i, retire_instr_i, drv_class};
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("rec_valid", 32'(rec_valid_o), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                check("rec_pc", rec_pc_o, exp_q[0][67:36]);
                check("rec_instr", rec_instr_o, exp_q[0][35:4]);
                check("rec_class", 32'(rec_class_o), 32'(exp_q[0][3:0]));
            end
            check("cnt_value", 32'(cnt_value_o), 32'(exp_cnt[cnt_sel_i]));
            check("dropped", 32'(dropped_o), 32'(exp_dropped));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        cnt_sel_i = cnt_sel_i + 4'd1;
    endtask

    task automatic retire(input logic [31:0] pc, input logic [31:0] instr, input logic [3:0] cls);
        retire_valid_i = 1'b1;
        retire_pc_i    = pc;
        retire_instr_i = instr;
        drv_class      = cls;
        tick();
        retire_valid_i = 1'b0;
    endtask

    task automatic check_cnt(input logic [3:0] sel, input logic [31:0] exp, input string name);
        cnt_sel_i = sel;
        #1;
        check(name, 32'(cnt_value_o), exp);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int drained;
        rst = 1'b1;
        retire_valid_i = 1'b0;
        retire_pc_i = '0;
        retire_instr_i = '0;
        rec_ready_i = 1'b1;
        cnt_sel_i = '0;
        cnt_clear_i = 1'b0;
        drv_class = '0;
        tick();
        cmp_en = 1'b1;
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_valid", 32'(rec_valid_o), 32'd0);
        check("rst_pc", rec_pc_o, 32'd0);
        check("rst_instr", rec_instr_o, 32'd0);
        check("rst_class", 32'(rec_class_o), 32'd0);
        check("rst_dropped", 32'(dropped_o), 32'd0);
        check_cnt(4'd0, 32'd0, "rst_cnt");

        // addi: two-cycle latency, no bypass
        retire(32'h0000_0100, ADDI, 4'd3);
        check("addi_no_bypass", 32'(rec_valid_o), 32'd0);
        tick();
        check("addi_valid", 32'(rec_valid_o), 32'd1);
        check("addi_class", 32'(rec_class_o), 32'd3);
        check("addi_pc", rec_pc_o, 32'h0000_0100);
        check_cnt(4'd3, 32'd1, "addi_cnt3");

        // Mixed classes back to back, including near-miss encodings
        retire(32'h0000_0104, 32'h0000_0063, 4'd2);   // beq
        retire(32'h0000_0108, 32'h0000_006F, 4'd1);   // jal
        retire(32'h0000_010C, 32'h0200_0033, 4'd4);   // mul
        retire(32'h0000_0110, 32'h0000_0073, 4'd7);   // ecall
        tick();
        tick();
        check_cnt(4'd2, 32'd1, "seq_cnt2");
        check_cnt(4'd1, 32'd1, "seq_cnt1");
        check_cnt(4'd4, 32'd1, "seq_cnt4");
        check_cnt(4'd7, 32'd1, "seq_cnt7");

        retire(32'h0000_0114, 32'h0000_00B7, 4'd0);   // lui
        retire(32'h0000_0118, 32'h3000_1073, 4'd6);   // csrrw
        retire(32'h0000_011C, 32'h0000_000F, 4'd5);   // fence
        retire(32'h0000_0120, 32'h4010_5093, 4'd3);   // srai
        retire(32'h0000_0124, 32'h4010_1093, 4'd15);  // slli with bad funct7
        retire(32'h0000_0128, 32'h0000_1067, 4'd15);  // jalr with f3=001
        retire(32'h0000_012C, 32'h1050_0073, 4'd7);   // wfi
        retire(32'h0000_0130, 32'h4000_0033, 4'd3);   // sub
        retire(32'h0000_0134, 32'h0400_0033, PAVG_CLS); // p.avg
        tick();
        tick();
        check_cnt(4'd3, 32'd3, "mix_cnt3");
        check_cnt(4'd8, (PAVG_CLS == 4'd8) ? 32'd1 : 32'd0, "pavg_cnt8");
        check_cnt(4'd15, (PAVG_CLS == 4'd8) ? 32'd2 : 32'd3, "mix_cnt15");
        check_cnt(4'd10, 32'd0, "reserved_cnt10");

        // Clear
        cnt_clear_i = 1'b1;
        tick();
        cnt_clear_i = 1'b0;
        check_cnt(4'd3, 32'd0, "clr_cnt3");
        check_cnt(4'd15, 32'd0, "clr_cnt15");

        // Overflow: 10 records into 8 slots with no consumer
        rec_ready_i = 1'b0;
        for (int i = 0; i < 10; i++) retire(32'h0000_0200 + 32'(4 * i), ADDI, 4'd3);
        tick();
        check("ovf_dropped", 32'(dropped_o), 32'd1);
        check_cnt(4'd3, 32'd10, "ovf_cnt3");
        check("ovf_head_pc", rec_pc_o, 32'h0000_0200);
        rec_ready_i = 1'b1;
        drained = 0;
        for (int c = 0; c < 20; c++) begin
            if (rec_valid_o) drained++;
            tick();
        end
        check("ovf_drained", 32'(drained), 32'd8);

        // Saturation at 15, then clear coincident with the 18th increment
        for (int i = 0; i < 7; i++) retire(32'h0000_0300 + 32'(4 * i), ADDI, 4'd3);
        tick();
        tick();
        check_cnt(4'd3, 32'd15, "sat_cnt3");
        check("sat_dropped", 32'(dropped_o), 32'd1);
        retire(32'h0000_0400, ADDI, 4'd3);
        cnt_clear_i = 1'b1;
        tick();
        cnt_clear_i = 1'b0;
        check_cnt(4'd3, 32'd0, "clr18_cnt3");
        check("clr18_dropped", 32'(dropped_o), 32'd0);
        check("clr18_fifo_kept", 32'(rec_valid_o), 32'd1);
        tick();
        tick();

        // Reset with queued records
        rec_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) retire(32'h0000_0500 + 32'(4 * i), ADDI, 4'd3);
        tick();
        tick();
        check("pre_rst_valid", 32'(rec_valid_o), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("post_rst_valid", 32'(rec_valid_o), 32'd0);
        check("post_rst_pc", rec_pc_o, 32'd0);
        check("post_rst_dropped", 32'(dropped_o), 32'd0);
        check_cnt(4'd3, 32'd0, "post_rst_cnt3");
        retire(32'h0000_0600, 32'h0000_0037, 4'd0);
        check("post_rst_s1", 32'(rec_valid_o), 32'd0);
        tick();
        check("post_rst_new_valid", 32'(rec_valid_o), 32'd1);
        check("post_rst_new_pc", rec_pc_o, 32'h0000_0600);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Time guard
    initial begin
        #200000;
        failures++;
        $display("FAIL timeout: got running expected finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
